// File: rtl/sram_responder.sv
// Target side of the SLC-3 asynchronous-SRAM bus: on-chip word array with byte-lane
// writes, programmable read wait states, registered turnaround and a side preload port.
module sram_responder #(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              CE,
    input  logic              UB,
    input  logic              LB,
    input  logic              OE,
    input  logic              WE,
    input  logic [19:0]       ADDR,
    inout  wire  [15:0]       Data,
    input  logic              Load_EN,
    input  logic [ADDR_W-1:0] Load_ADDR,
    input  logic [15:0]       Load_DATA,
    output logic              Rd_Valid,
    output logic              Oob,
    output logic              Collision
);

    localparam int         DEPTH      = 1 << ADDR_W;
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_RWAIT    = 2'd1;
    localparam logic [1:0] S_RDRIVE   = 2'd2;
    localparam logic [2:0] LAT_RELOAD = 3'(READ_LAT - 1);

    logic [15:0] r_mem [DEPTH];
    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [19:0] r_addr;
    logic        r_oob;
    logic        r_coll;

    logic        w_write;
    logic        w_read;
    logic        w_oob;
    logic        w_same;
    logic        w_capture;
    logic        w_drv;
    logic [15:0] w_rdata;

    assign w_write = !CE && !WE;
    assign w_read  = !CE && !OE && WE;
    assign w_oob   = |ADDR[19:ADDR_W];
    assign w_same  = (ADDR == r_addr);

    // A new read access starts on entry from IDLE or whenever the address moves mid-read.
    always_comb begin
        w_capture = 1'b0;
        case (r_state)
            S_IDLE:            w_capture = w_read;
            S_RWAIT, S_RDRIVE: w_capture = w_read && !w_same;
            default:           w_capture = 1'b0;
        endcase
    end

    // Preload owns the array port on a collision; the bus write is dropped entirely.
    always_ff @(posedge Clk) begin
        if (Load_EN) begin
            r_mem[Load_ADDR] <= Load_DATA;
        end else if (w_write && !w_oob) begin
            if (!UB) r_mem[ADDR[ADDR_W-1:0]][15:8] <= Data[15:8];
            if (!LB) r_mem[ADDR[ADDR_W-1:0]][7:0]  <= Data[7:0];
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= 20'd0;
            r_oob   <= 1'b0;
            r_coll  <= 1'b0;
        end else begin
            r_oob  <= w_oob && (w_write || w_capture);
            r_coll <= Load_EN && w_write;
            if (w_capture) r_addr <= ADDR;
            case (r_state)
                S_IDLE: begin
                    if (w_read) begin
                        r_cnt   <= LAT_RELOAD;
                        r_state <= (READ_LAT == 1) ? S_RDRIVE : S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    if (!w_read) begin
                        r_state <= S_IDLE;
                    end else if (!w_same) begin
                        r_cnt <= LAT_RELOAD;
                    end else if (r_cnt <= 3'd1) begin
                        r_cnt   <= 3'd0;
                        r_state <= S_RDRIVE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_RDRIVE: begin
                    if (!w_read) begin
                        r_state <= S_IDLE;
                    end else if (!w_same) begin
                        r_cnt   <= LAT_RELOAD;
                        r_state <= (READ_LAT == 1) ? S_RDRIVE : S_RWAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Out-of-range reads return zero; live array read so a preload shows up next cycle.
    assign w_rdata = (|r_addr[19:ADDR_W]) ? 16'h0000 : r_mem[r_addr[ADDR_W-1:0]];
    assign w_drv   = (r_state == S_RDRIVE);

    assign Data[15:8] = (w_drv && !UB) ? w_rdata[15:8] : 8'hzz;
    assign Data[7:0]  = (w_drv && !LB) ? w_rdata[7:0]  : 8'hzz;

    assign Rd_Valid  = w_drv;
    assign Oob       = r_oob;
    assign Collision = r_coll;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboarded bench for sram_responder: two instances (READ_LAT 1 and 3) share one
// stimulus stream; a run-length reference model predicts every post-edge output.
`timescale 1ns/1ps
module tb_sram_responder;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset, CE, UB, LB, OE, WE, Load_EN;
    logic [19:0] ADDR;
    logic [9:0]  Load_ADDR;
    logic [15:0] Load_DATA, tb_d;
    wire  [15:0] Data1, Data3;
    logic        Rd_Valid1, Oob1, Coll1, Rd_Valid3, Oob3, Coll3;
    logic        tb_wr;

    assign tb_wr = !CE && !WE;
    assign Data1 = tb_wr ? tb_d : 16'hzzzz;
    assign Data3 = tb_wr ? tb_d : 16'hzzzz;

    sram_responder #(.ADDR_W(10), .READ_LAT(1)) u_lat1 (
        .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .ADDR(ADDR), .Data(Data1), .Load_EN(Load_EN), .Load_ADDR(Load_ADDR),
        .Load_DATA(Load_DATA), .Rd_Valid(Rd_Valid1), .Oob(Oob1), .Collision(Coll1));

    sram_responder #(.ADDR_W(10), .READ_LAT(3)) u_lat3 (
        .Clk(Clk), .Reset(Reset), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .ADDR(ADDR), .Data(Data3), .Load_EN(Load_EN), .Load_ADDR(Load_ADDR),
        .Load_DATA(Load_DATA), .Rd_Valid(Rd_Valid3), .Oob(Oob3), .Collision(Coll3));

    typedef struct packed {
        logic        vld;
        logic        oob;
        logic        coll;
        logic        hi;
        logic        lo;
        logic [15:0] word;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mdl_mem [1024];
    int          run = 0;
    logic [19:0] prev_addr = 20'd0;

    function automatic logic released(input logic [7:0] b);
        return $isunknown(b) || (b == 8'h00);
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic chk_rel(input string nm, input logic [7:0] b);
        checks++;
        if (!released(b)) begin
            errors++;
            $display("FAIL %s actual %h required released at %0t", nm, b, $time);
        end
    endtask

    task automatic mon_one(input string dn, input exp_t e, input logic v, input logic o,
                           input logic c, input logic [15:0] d);
        chk({dn, ".rd_valid"},  16'(v), 16'(e.vld));
        chk({dn, ".oob"},       16'(o), 16'(e.oob));
        chk({dn, ".collision"}, 16'(c), 16'(e.coll));
        if (e.vld && e.hi)  chk({dn, ".data_hi"}, 16'(d[15:8]), 16'(e.word[15:8]));
        else if (!tb_wr)    chk_rel({dn, ".hi_released"}, d[15:8]);
        if (e.vld && e.lo)  chk({dn, ".data_lo"}, 16'(d[7:0]), 16'(e.word[7:0]));
        else if (!tb_wr)    chk_rel({dn, ".lo_released"}, d[7:0]);
    endtask

    // Monitor: one expectation per clock edge per instance, sampled just after the edge.
    initial begin
        exp_t e1, e3;
        forever begin
            @(posedge Clk);
            #1;
            if (q1.size() > 0) begin
                e1 = q1.pop_front();
                mon_one("lat1", e1, Rd_Valid1, Oob1, Coll1, Data1);
            end
            if (q3.size() > 0) begin
                e3 = q3.pop_front();
                mon_one("lat3", e3, Rd_Valid3, Oob3, Coll3, Data3);
            end
        end
    end

    // Reference: a read has been qualified on `run` consecutive edges at one address;
    // data is driven once run reaches the instance's latency.
    task automatic model_step();
        exp_t        e;
        logic        wr, rd, oob;
        logic [15:0] w;
        e = '0;
        if (!Reset) begin
            run = 0;
            q1.push_back(e);
            q3.push_back(e);
            return;
        end
        wr  = !CE && !WE;
        rd  = !CE && !OE && WE;
        oob = |ADDR[19:10];
        if (Load_EN) mdl_mem[Load_ADDR] = Load_DATA;
        else if (wr && !oob) begin
            if (!UB) mdl_mem[ADDR[9:0]][15:8] = tb_d[15:8];
            if (!LB) mdl_mem[ADDR[9:0]][7:0]  = tb_d[7:0];
        end
        run       = rd ? ((run > 0 && ADDR == prev_addr) ? run + 1 : 1) : 0;
        prev_addr = ADDR;
        w         = oob ? 16'h0000 : mdl_mem[ADDR[9:0]];
        e.oob     = oob && (wr || run == 1);
        e.coll    = Load_EN && wr;
        e.hi      = !UB;
        e.lo      = !LB;
        e.word    = w;
        e.vld     = (run >= 1);
        q1.push_back(e);
        e.vld     = (run >= 3);
        q3.push_back(e);
    endtask

    task automatic cycle();
        model_step();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic bus(input logic ce, input logic oe, input logic we, input logic ub,
                       input logic lb, input logic [19:0] a, input logic [15:0] d);
        CE = ce; OE = oe; WE = we; UB = ub; LB = lb; ADDR = a; tb_d = d;
    endtask

    task automatic idle();
        bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'd0, 16'd0);
        Load_EN = 1'b0;
        cycle();
    endtask

    task automatic rd(input logic [19:0] a, input logic ub, input logic lb, input int n);
        repeat (n) begin
            bus(1'b0, 1'b0, 1'b1, ub, lb, a, 16'd0);
            Load_EN = 1'b0;
            cycle();
        end
    endtask

    task automatic wr(input logic [19:0] a, input logic [15:0] d, input logic ub,
                      input logic lb, input int n);
        repeat (n) begin
            bus(1'b0, 1'b0, 1'b0, ub, lb, a, d);
            Load_EN = 1'b0;
            cycle();
        end
    endtask

    task automatic ld(input logic [9:0] a, input logic [15:0] d);
        bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'd0, 16'd0);
        Load_EN = 1'b1; Load_ADDR = a; Load_DATA = d;
        cycle();
        Load_EN = 1'b0;
    endtask

    task automatic rnd_load();
        Load_EN   = ($urandom_range(0, 7) == 0);
        Load_ADDR = 10'($urandom_range(0, 15));
        Load_DATA = 16'($urandom);
    endtask

    function automatic logic [19:0] raddr();
        if ($urandom_range(0, 7) == 0)
            return {10'($urandom_range(1, 1023)), 10'($urandom_range(0, 15))};
        return 20'($urandom_range(0, 15));
    endfunction

    initial begin
        Reset = 1'b1;
        bus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 20'd0, 16'd0);
        Load_EN = 1'b0; Load_ADDR = 10'd0; Load_DATA = 16'd0;
        #1 Reset = 1'b0;
        repeat (3) cycle();
        Reset = 1'b1;

        for (int i = 0; i < 1024; i++) ld(10'(i), 16'($urandom));
        ld(10'd5, 16'h1234);
        ld(10'd6, 16'hABCD);

        // Latency and address-change behaviour
        rd(20'd5, 1'b0, 1'b0, 3);
        rd(20'd6, 1'b0, 1'b0, 4);
        idle();
        rd(20'd6, 1'b0, 1'b0, 2);
        rd(20'd5, 1'b0, 1'b0, 4);
        idle();

        // Byte-masked write and lane-gated read
        wr(20'd5, 16'hFF00, 1'b0, 1'b1, 1);
        idle();
        rd(20'd5, 1'b0, 1'b0, 3);
        rd(20'd5, 1'b1, 1'b0, 3);
        idle();

        // WE priority over OE, held write
        wr(20'd7, 16'h5555, 1'b0, 1'b0, 2);
        idle();
        rd(20'd7, 1'b0, 1'b0, 3);
        idle();

        // Out-of-bounds access
        wr(20'h00400, 16'hDEAD, 1'b0, 1'b0, 1);
        idle();
        rd(20'h00400, 1'b0, 1'b0, 3);
        idle();
        rd(20'd0, 1'b0, 1'b0, 3);
        idle();

        // Preload vs bus write collision
        bus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20'h00011, 16'h1111);
        Load_EN = 1'b1; Load_ADDR = 10'h010; Load_DATA = 16'hBEEF;
        cycle();
        idle();
        rd(20'h00011, 1'b0, 1'b0, 3);
        idle();
        rd(20'h00010, 1'b0, 1'b0, 3);
        idle();

        // Preload into the word being read
        rd(20'd6, 1'b0, 1'b0, 3);
        bus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20'd6, 16'd0);
        Load_EN = 1'b1; Load_ADDR = 10'd6; Load_DATA = 16'h6666;
        cycle();
        rd(20'd6, 1'b0, 1'b0, 2);
        idle();

        // Randomized traffic
        for (int t = 0; t < 400; t++) begin
            int          k;
            int          n;
            logic [19:0] a;
            k = $urandom_range(0, 9);
            n = $urandom_range(1, 5);
            a = raddr();
            if (k <= 5) begin
                for (int c = 0; c < n + 2; c++) begin
                    if ($urandom_range(0, 4) == 0) a = raddr();
                    bus(1'b0, 1'b0, 1'b1, ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 3) == 0), a, 16'd0);
                    rnd_load();
                    cycle();
                end
            end else if (k <= 7) begin
                for (int c = 0; c < n; c++) begin
                    bus(1'b0, 1'($urandom), 1'b0, ($urandom_range(0, 3) == 0),
                        ($urandom_range(0, 3) == 0), a, 16'($urandom));
                    rnd_load();
                    cycle();
                end
            end else if (k == 8) begin
                ld(10'($urandom_range(0, 15)), 16'($urandom));
            end
            idle();
        end

        // Asynchronous reset while driving
        ld(10'd6, 16'hC3A5);
        rd(20'd6, 1'b0, 1'b0, 4);
        Reset = 1'b0;
        #1;
        chk("rst_async.lat1.rd_valid", 16'(Rd_Valid1), 16'd0);
        chk("rst_async.lat3.rd_valid", 16'(Rd_Valid3), 16'd0);
        chk_rel("rst_async.lat1.hi", Data1[15:8]);
        chk_rel("rst_async.lat1.lo", Data1[7:0]);
        chk_rel("rst_async.lat3.hi", Data3[15:8]);
        chk_rel("rst_async.lat3.lo", Data3[7:0]);
        cycle();
        cycle();
        Reset = 1'b1;
        idle();
        rd(20'd6, 1'b0, 1'b0, 4);
        idle();

        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable target side of the SLC-3 asynchronous-SRAM bus. It answers the active-low CE/UB/LB/OE/WE strobes, the 20-bit ADDR and the bidirectional 16-bit Data that the CPU's memory subsystem initiates.
- Backed by an on-chip word array with byte-lane writes, programmable read wait states and registered bus-turnaround control.
- Used as an SRAM stand-in for on-chip bring-up and as the bus-functional target in CPU-level simulation.
- A side preload port fills program memory before Run.

Parameters:
- ADDR_W, 10, word-address bits implemented; depth is 2**ADDR_W words.
- READ_LAT, 1, cycles from read qualification to Data driven; legal range 1 to 7.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- CE  input  1  chip enable, active low.
- UB  input  1  upper-byte lane enable, active low; Data[15:8].
- LB  input  1  lower-byte lane enable, active low; Data[7:0].
- OE  input  1  output enable, active low.
- WE  input  1  write enable, active low.
- ADDR  input  20  word address.
- Data  inout  16  bidirectional bus (wire); high-Z unless this block drives it.
- Load_EN  input  1  preload write strobe, active high.
- Load_ADDR  input  ADDR_W  preload word address.
- Load_DATA  input  16  preload word.
- Rd_Valid  output  1  high while Data is being driven.
- Oob  output  1  one-cycle pulse on an access with ADDR at or above depth.
- Collision  output  1  one-cycle pulse when a preload and a bus write occur in the same cycle.

Behaviour:
- Reset, while low:
  - State IDLE; wait counter 0; lane drive enables cleared asynchronously, so Data is high-Z.
  - Rd_Valid, Oob and Collision all 0.
  - Array contents are not cleared.
- Qualifiers, sampled at each rising edge:
  - write = CE=0 and WE=0.
  - read = CE=0, OE=0 and WE=1.
  - WE has priority: CE=OE=WE=0 is a write, and Data is never driven.
- State IDLE:
  - write -> array updated this edge; stay IDLE.
  - read -> capture ADDR; counter = READ_LAT-1; next state RWAIT, or RDRIVE if READ_LAT=1.
- State RWAIT:
  - Counter decrements each cycle; at 0 go to RDRIVE.
  - Read dropped (CE, OE or WE deasserted) -> IDLE.
  - ADDR differs from captured value -> recapture ADDR and reload the counter (restart).
- State RDRIVE:
  - Rd_Valid=1.
  - Data[15:8] driven from array[captured ADDR] only while UB=0; Data[7:0] only while LB=0. A disabled lane is high-Z.
  - Drive enables come from the registered state; lane gating with UB/LB is combinational.
  - ADDR change -> release Data next edge and re-enter RWAIT; with READ_LAT=1, re-enter RDRIVE with the new word.
  - Read dropped -> IDLE; Data released at that same edge (one-cycle turnaround, no bus overlap).
  - A write qualifier has priority -> write performed, IDLE, Data released.
- Writes:
  - Byte-masked: UB=0 updates [15:8], LB=0 updates [7:0]; UB=LB=1 writes nothing.
  - A write is committed on every edge where it is qualified; holding a write for N cycles rewrites the same data.
- Address decoding:
  - Word index = ADDR[ADDR_W-1:0].
  - ADDR[19:ADDR_W] nonzero -> out of bounds: write dropped, read drives 0x0000 on enabled lanes, Oob pulses once per qualified access start (write edge or read capture).
- Preload:
  - Load_EN=1 writes Load_DATA as a full word at the next edge, in any state.
  - Same edge as a bus write: preload wins and the bus write is dropped entirely, even to a different address; Collision pulses.
  - Preload to the word currently being read: the new value appears on Data the following cycle.
- Read-after-write to the same address returns the new data. There is no bypass hazard because a read needs at least one cycle after the write edge.

Test Plan:
- Preload 0x1234 to address 5 and 0xABCD to address 6; READ_LAT=1; CE=OE=0, WE=1, ADDR=5, UB=LB=0 -> Data=0x1234 and Rd_Valid=1 one cycle after qualification. Change ADDR to 6 -> Data=0xABCD next cycle.
- READ_LAT=3; read address 6 -> Data high-Z for 2 cycles, 0xABCD on cycle 3. Change ADDR mid-wait -> counter restarts, with 3 more cycles to drive.
- Write 0xFF00 with UB=0, LB=1 to address 5 (holding 0x1234) -> read returns 0xFF34. Read with UB=1, LB=0 -> Data[15:8]=Z, Data[7:0]=0x34.
- CE=OE=WE=0, ADDR=7, bus Data=0x5555 from the bench -> memory[7]=0x5555, block never drives Data, and a later read of address 7 returns 0x5555.
- ADDR=0x00400 (ADDR_W=10) write then read -> Oob pulses on each access, read data 0x0000, and memory[0] unchanged.
- Load_EN and a bus write in the same cycle -> Collision=1 for one cycle, and only the preload word lands. Assert Reset low during RDRIVE -> Data high-Z immediately, Rd_Valid=0, array contents preserved.
